crc_bus_host: RTL and testbench

- Bus initiator that drives the memory-mapped CRC-32C peripheral on behalf of on-chip logic.
- Takes a byte stream over a valid/ready handshake and converts each message into a register sequence on the peripheral's strobe bus:
  - CLR;
  - per byte: write IN, then PUT;
  - GET, poll STATUS, read RESULT.
- Returns the 32-bit CRC, or an error indication, to the requester.

---
 rtl/crc_bus_host_if.sv | 29 ++
 rtl/crc_bus_host.sv | 244 ++++++++++++++++++++++++
 tb/tb_crc_bus_host.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/crc_bus_host_if.sv
// Requester byte stream, result/error reporting and peripheral strobe bus
// for crc_bus_host, bundled with host-side (master) and environment-side (slave) views.
interface crc_bus_host_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_last;
  logic        in_ready;
  logic        crc_valid;
  logic [31:0] crc_out;
  logic        err;
  logic [1:0]  err_code;
  logic [15:0] saddress;
  logic        swr;
  logic        srd;
  logic [31:0] sdata_out;
  logic [31:0] sdata_in;

  modport master (
    input  in_valid, in_data, in_last, sdata_in,
    output in_ready, crc_valid, crc_out, err, err_code,
    output saddress, swr, srd, sdata_out
  );

  modport slave (
    output in_valid, in_data, in_last, sdata_in,
    input  in_ready, crc_valid, crc_out, err, err_code,
    input  saddress, swr, srd, sdata_out
  );
endinterface

// File: rtl/crc_bus_host.sv
// Bus initiator for the memory-mapped CRC-32C peripheral: turns each requester
// message into CLR / IN+PUT per byte / GET / STATUS poll / RESULT accesses.
module crc_bus_host #(
  parameter int STROBE_LEN    = 2,
  parameter int CMD_GAP       = 4,
  parameter int POLL_INTERVAL = 8,
  parameter int POLL_TIMEOUT  = 4096,
  parameter int MAX_BYTES     = 249
) (
  input logic            clk,
  input logic            n_reset,
  crc_bus_host_if.master bus
);

  localparam logic [15:0] ADDR_IN     = 16'h0640;
  localparam logic [15:0] ADDR_STATUS = 16'h0648;
  localparam logic [15:0] ADDR_RESULT = 16'h0650;
  localparam logic [15:0] ADDR_CTRL   = 16'h0658;
  localparam logic [31:0] CMD_PUT     = 32'd1;
  localparam logic [31:0] CMD_GET     = 32'd2;
  localparam logic [31:0] CMD_CLR     = 32'd3;
  localparam int          READY_BIT   = 3;
  localparam int          ERROR_BIT   = 4;

  localparam int              PW        = $clog2(POLL_TIMEOUT + 1);
  localparam logic [15:0]     STB_LAST  = 16'(STROBE_LEN - 1);
  localparam logic [15:0]     GAP_LAST  = 16'(CMD_GAP - 1);
  localparam logic [15:0]     POLL_LAST = 16'(POLL_INTERVAL - 1);
  localparam logic [PW-1:0]   POLL_MAX  = PW'(POLL_TIMEOUT);
  localparam logic [7:0]      BYTE_MAX  = 8'(MAX_BYTES);

  typedef enum logic [3:0] {
    ST_IDLE, ST_CLR, ST_WR_IN, ST_WR_PUT, ST_NEXT, ST_DRAIN, ST_GET, ST_POLL, ST_RES
  } state_t;

  typedef enum logic [1:0] {PH_SETUP, PH_STROBE, PH_HOLD, PH_WAIT} phase_t;

  state_t        state_r;
  phase_t        ph_r;
  logic [15:0]   cnt_r;
  logic [PW-1:0] poll_cnt_r;
  logic [7:0]    byte_cnt_r;
  logic [7:0]    byte_r;
  logic          last_r;
  logic          in_ready_r;
  logic          crc_valid_r;
  logic [31:0]   crc_out_r;
  logic          err_r;
  logic [1:0]    err_code_r;
  logic [15:0]   saddress_r;
  logic          swr_r;
  logic          srd_r;
  logic [31:0]   sdata_out_r;

  // Message sequencer: each bus state runs SETUP/STROBE/HOLD, CTRL writes and polls add WAIT.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_r     <= ST_IDLE;
      ph_r        <= PH_SETUP;
      cnt_r       <= 16'd0;
      poll_cnt_r  <= '0;
      byte_cnt_r  <= 8'd0;
      byte_r      <= 8'd0;
      last_r      <= 1'b0;
      in_ready_r  <= 1'b0;
      crc_valid_r <= 1'b0;
      crc_out_r   <= 32'd0;
      err_r       <= 1'b0;
      err_code_r  <= 2'd0;
      saddress_r  <= 16'd0;
      swr_r       <= 1'b0;
      srd_r       <= 1'b0;
      sdata_out_r <= 32'd0;
    end else begin
      crc_valid_r <= 1'b0;
      err_r       <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          in_ready_r <= 1'b1;
          if (bus.in_valid && in_ready_r) begin
            in_ready_r  <= 1'b0;
            byte_r      <= bus.in_data;
            last_r      <= bus.in_last;
            byte_cnt_r  <= 8'd1;
            state_r     <= ST_CLR;
            ph_r        <= PH_SETUP;
            cnt_r       <= 16'd0;
            saddress_r  <= ADDR_CTRL;
            sdata_out_r <= CMD_CLR;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_NEXT: begin
          if (bus.in_valid && in_ready_r) begin
            if (byte_cnt_r == BYTE_MAX) begin
              // Overflow byte may itself close the message; otherwise swallow the rest.
              err_r      <= 1'b1;
              err_code_r <= 2'd1;
              state_r    <= bus.in_last ? ST_IDLE : ST_DRAIN;
            end else begin
              in_ready_r  <= 1'b0;
              byte_r      <= bus.in_data;
              last_r      <= bus.in_last;
              byte_cnt_r  <= byte_cnt_r + 8'd1;
              state_r     <= ST_WR_IN;
              ph_r        <= PH_SETUP;
              cnt_r       <= 16'd0;
              saddress_r  <= ADDR_IN;
              sdata_out_r <= {24'd0, bus.in_data};
            end
          end else begin
            state_r <= ST_NEXT;
          end
        end
        ST_DRAIN: begin
          if (bus.in_valid && in_ready_r && bus.in_last) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_DRAIN;
          end
        end
        ST_CLR, ST_WR_IN, ST_WR_PUT, ST_GET, ST_POLL, ST_RES: begin
          case (ph_r)
            PH_SETUP: begin
              ph_r  <= PH_STROBE;
              cnt_r <= 16'd0;
              if (state_r == ST_POLL || state_r == ST_RES) begin
                srd_r <= 1'b1;
              end else begin
                swr_r <= 1'b1;
              end
            end
            PH_STROBE: begin
              if (cnt_r == STB_LAST) begin
                swr_r <= 1'b0;
                srd_r <= 1'b0;
                ph_r  <= PH_HOLD;
                cnt_r <= 16'd0;
              end else begin
                cnt_r <= cnt_r + 16'd1;
              end
            end
            PH_HOLD: begin
              saddress_r  <= 16'd0;
              sdata_out_r <= 32'd0;
              cnt_r       <= 16'd0;
              case (state_r)
                ST_WR_IN: begin
                  state_r     <= ST_WR_PUT;
                  ph_r        <= PH_SETUP;
                  saddress_r  <= ADDR_CTRL;
                  sdata_out_r <= CMD_PUT;
                end
                ST_POLL: begin
                  if (bus.sdata_in[ERROR_BIT]) begin
                    err_r      <= 1'b1;
                    err_code_r <= 2'd2;
                    state_r    <= ST_IDLE;
                    ph_r       <= PH_SETUP;
                    in_ready_r <= 1'b1;
                  end else if (bus.sdata_in[READY_BIT]) begin
                    state_r    <= ST_RES;
                    ph_r       <= PH_SETUP;
                    saddress_r <= ADDR_RESULT;
                  end else if (poll_cnt_r + PW'(1) == POLL_MAX) begin
                    err_r      <= 1'b1;
                    err_code_r <= 2'd3;
                    state_r    <= ST_IDLE;
                    ph_r       <= PH_SETUP;
                    in_ready_r <= 1'b1;
                  end else begin
                    poll_cnt_r <= poll_cnt_r + PW'(1);
                    ph_r       <= PH_WAIT;
                  end
                end
                ST_RES: begin
                  crc_out_r   <= bus.sdata_in;
                  crc_valid_r <= 1'b1;
                  state_r     <= ST_IDLE;
                  ph_r        <= PH_SETUP;
                  in_ready_r  <= 1'b1;
                end
                default: ph_r <= PH_WAIT;
              endcase
            end
            PH_WAIT: begin
              if ((state_r == ST_POLL && cnt_r == POLL_LAST) ||
                  (state_r != ST_POLL && cnt_r == GAP_LAST)) begin
                cnt_r <= 16'd0;
                ph_r  <= PH_SETUP;
                case (state_r)
                  ST_CLR: begin
                    state_r     <= ST_WR_IN;
                    saddress_r  <= ADDR_IN;
                    sdata_out_r <= {24'd0, byte_r};
                  end
                  ST_WR_PUT: begin
                    if (last_r) begin
                      state_r     <= ST_GET;
                      saddress_r  <= ADDR_CTRL;
                      sdata_out_r <= CMD_GET;
                    end else begin
                      state_r    <= ST_NEXT;
                      in_ready_r <= 1'b1;
                    end
                  end
                  ST_GET: begin
                    state_r    <= ST_POLL;
                    poll_cnt_r <= '0;
                    saddress_r <= ADDR_STATUS;
                  end
                  ST_POLL: saddress_r <= ADDR_STATUS;
                  default: begin
                    state_r    <= ST_IDLE;
                    in_ready_r <= 1'b1;
                  end
                endcase
              end else begin
                cnt_r <= cnt_r + 16'd1;
              end
            end
            default: ph_r <= PH_SETUP;
          endcase
        end
        default: begin
          state_r <= ST_IDLE;
          ph_r    <= PH_SETUP;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.crc_valid = crc_valid_r;
  assign bus.crc_out   = crc_out_r;
  assign bus.err       = err_r;
  assign bus.err_code  = err_code_r;
  assign bus.saddress  = saddress_r;
  assign bus.swr       = swr_r;
  assign bus.srd       = srd_r;
  assign bus.sdata_out = sdata_out_r;

endmodule

// File: tb/tb_crc_bus_host.sv
// Scoreboard bench for crc_bus_host: directed messages against a CRC-32C peripheral
// model; expected bus accesses and results are queued and popped by monitors.
module tb_crc_bus_host;
  localparam int STROBE_LEN    = 2;
  localparam int CMD_GAP       = 4;
  localparam int POLL_INTERVAL = 8;
  localparam int POLL_TIMEOUT  = 16;
  localparam int MAX_BYTES     = 249;
  localparam logic [15:0] A_IN     = 16'h0640;
  localparam logic [15:0] A_STATUS = 16'h0648;
  localparam logic [15:0] A_RESULT = 16'h0650;
  localparam logic [15:0] A_CTRL   = 16'h0658;

  typedef struct packed {
    logic        rd;
    logic [15:0] addr;
    logic [31:0] data;
  } acc_t;

  typedef struct packed {
    logic        is_err;
    logic [31:0] val;
  } res_t;

  logic clk = 1'b0;
  logic n_reset;
  longint cyc = 0;

  always #5 clk = ~clk;

  // Free-running cycle count used for poll spacing.
  always @(posedge clk) cyc <= cyc + 1;

  crc_bus_host_if bus_if ();

  crc_bus_host #(
    .STROBE_LEN(STROBE_LEN), .CMD_GAP(CMD_GAP), .POLL_INTERVAL(POLL_INTERVAL),
    .POLL_TIMEOUT(POLL_TIMEOUT), .MAX_BYTES(MAX_BYTES)
  ) dut (
    .clk(clk), .n_reset(n_reset), .bus(bus_if)
  );

  int checks = 0;
  int errors = 0;
  acc_t exp_bus[$];
  res_t exp_res[$];
  logic [7:0] msg[$];
  int stat_mode = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  function automatic logic [127:0] outs();
    return {41'd0, bus_if.in_ready, bus_if.crc_valid, bus_if.crc_out, bus_if.err,
            bus_if.err_code, bus_if.saddress, bus_if.swr, bus_if.srd, bus_if.sdata_out};
  endfunction

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'd0, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'h82F63B78) : (r >> 1);
    return r;
  endfunction

  function automatic logic [31:0] status_for(input int mode, input int idx);
    if (mode == 0) return 32'h0000_0008;
    if (mode == 1) return (idx < 2) ? 32'h0 : 32'h0000_0010;
    return 32'h0;
  endfunction

  // Peripheral model: CRC-32C engine behind the register map, scripted STATUS.
  initial begin
    logic pw, ps;
    logic [31:0] crc_acc;
    logic [7:0] in_reg;
    int poll_idx;
    pw = 1'b0; ps = 1'b0; crc_acc = 32'hFFFF_FFFF; in_reg = 8'd0; poll_idx = 0;
    bus_if.sdata_in = 32'd0;
    forever begin
      @(negedge clk);
      if (bus_if.swr && !pw) begin
        if (bus_if.saddress == A_IN) in_reg = bus_if.sdata_out[7:0];
        else if (bus_if.saddress == A_CTRL) begin
          if (bus_if.sdata_out == 32'd3) begin crc_acc = 32'hFFFF_FFFF; poll_idx = 0; end
          else if (bus_if.sdata_out == 32'd1) crc_acc = crc_byte(crc_acc, in_reg);
          else if (bus_if.sdata_out == 32'd2) poll_idx = 0;
        end
      end
      if (bus_if.srd && !ps) begin
        if (bus_if.saddress == A_STATUS) begin
          bus_if.sdata_in = status_for(stat_mode, poll_idx);
          poll_idx++;
        end else if (bus_if.saddress == A_RESULT) bus_if.sdata_in = ~crc_acc;
        else bus_if.sdata_in = 32'd0;
      end
      pw = bus_if.swr;
      ps = bus_if.srd;
    end
  end

  // Bus monitor: every strobe start is popped against the expected access queue.
  initial begin
    logic pw, ps, prev_stat;
    longint last_stat;
    acc_t act, e;
    pw = 1'b0; ps = 1'b0; prev_stat = 1'b0; last_stat = 0;
    forever begin
      @(negedge clk);
      if (bus_if.swr && bus_if.srd) flag("strobe overlap");
      if ((bus_if.swr && !pw) || (bus_if.srd && !ps)) begin
        act.rd   = bus_if.srd;
        act.addr = bus_if.saddress;
        act.data = bus_if.srd ? 32'd0 : bus_if.sdata_out;
        if (exp_bus.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected bus access: got 0x%0h expected none", act);
        end else begin
          e = exp_bus.pop_front();
          chk("bus access", 128'(act), 128'(e));
        end
        if (act.rd && act.addr == A_STATUS) begin
          if (prev_stat) chk("poll spacing", 128'(cyc - last_stat), 128'(2 + STROBE_LEN + POLL_INTERVAL));
          prev_stat = 1'b1;
          last_stat = cyc;
        end else prev_stat = 1'b0;
      end
      pw = bus_if.swr;
      ps = bus_if.srd;
      if (!n_reset) begin pw = 1'b0; ps = 1'b0; prev_stat = 1'b0; end
    end
  end

  // Result monitor: each crc_valid / err pulse is popped against the expected result.
  initial begin
    res_t e;
    forever begin
      @(negedge clk);
      if (n_reset === 1'b1 && (bus_if.crc_valid || bus_if.err)) begin
        if (bus_if.crc_valid && bus_if.err) flag("crc_valid and err together");
        if (exp_res.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected result: got crc_valid=%0b err=%0b expected none", bus_if.crc_valid, bus_if.err);
        end else begin
          e = exp_res.pop_front();
          chk("result is_err", 128'(bus_if.err), 128'(e.is_err));
          if (e.is_err) chk("err_code", 128'(bus_if.err_code), 128'(e.val));
          else chk("crc_out", 128'(bus_if.crc_out), 128'(e.val));
        end
      end
    end
  end

  task automatic exp_w(input logic [15:0] a, input logic [31:0] d);
    exp_bus.push_back('{1'b0, a, d});
  endtask

  task automatic exp_r(input logic [15:0] a);
    exp_bus.push_back('{1'b1, a, 32'd0});
  endtask

  // Expected accesses for CLR plus the first n IN/PUT pairs of msg.
  task automatic exp_bytes(input int n);
    exp_w(A_CTRL, 32'd3);
    for (int i = 0; i < n; i++) begin
      exp_w(A_IN, {24'd0, msg[i]});
      exp_w(A_CTRL, 32'd1);
    end
  endtask

  task automatic exp_tail(input int polls, input logic is_err, input logic [31:0] v);
    exp_w(A_CTRL, 32'd2);
    for (int i = 0; i < polls; i++) exp_r(A_STATUS);
    if (!is_err) exp_r(A_RESULT);
    exp_res.push_back('{is_err, v});
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l, input int idle);
    int t;
    bus_if.in_valid = 1'b0;
    repeat (idle) @(negedge clk);
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = d;
    bus_if.in_last  = l;
    t = 0;
    while (bus_if.in_ready !== 1'b1 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) flag("in_ready timeout");
    @(negedge clk);
    bus_if.in_valid = 1'b0;
  endtask

  task automatic send_msg(input logic rnd);
    for (int i = 0; i < msg.size(); i++)
      send_byte(msg[i], (i == msg.size() - 1), rnd ? int'($urandom_range(0, 3)) : 0);
  endtask

  task automatic wait_done(input string name);
    int t;
    t = 0;
    while ((exp_res.size() != 0 || exp_bus.size() != 0) && t < 20000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20000) flag({name, " completion timeout"});
    repeat (30) @(negedge clk);
    chk({name, " bus queue empty"}, 128'(exp_bus.size()), 128'd0);
  endtask

  initial begin
    int t;
    n_reset = 1'b0;
    bus_if.in_valid = 1'b0;
    bus_if.in_data  = 8'd0;
    bus_if.in_last  = 1'b0;
    repeat (3) @(negedge clk);
    chk("outputs in reset", outs(), 128'd0);
    n_reset = 1'b1;
    @(negedge clk);
    chk("in_ready after reset", 128'(bus_if.in_ready), 128'd1);

    // Reset while the PUT write strobe is high.
    msg = '{8'hAA};
    exp_bytes(1);
    send_byte(8'hAA, 1'b0, 0);
    t = 0;
    while (!(bus_if.swr && bus_if.saddress == A_CTRL && bus_if.sdata_out == 32'd1) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) flag("PUT strobe timeout");
    n_reset = 1'b0;
    @(negedge clk);
    chk("swr after mid-strobe reset", 128'(bus_if.swr), 128'd0);
    chk("outputs after mid-strobe reset", outs(), 128'd0);
    n_reset = 1'b1;
    @(negedge clk);
    chk("in_ready after release", 128'(bus_if.in_ready), 128'd1);
    chk("mid-strobe bus queue", 128'(exp_bus.size()), 128'd0);

    // Single byte '1', READY on first poll.
    stat_mode = 0;
    msg = '{8'h31};
    exp_bytes(1);
    exp_tail(1, 1'b0, 32'h90F599E3);
    send_msg(1'b0);
    wait_done("single byte");
    chk("crc_out held", 128'(bus_if.crc_out), 128'h90F599E3);

    // "123456789" with random gaps on in_valid.
    msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    exp_bytes(9);
    exp_tail(1, 1'b0, 32'hE3069283);
    send_msg(1'b1);
    wait_done("check string");

    // 252-byte message: overflow on byte 250, remainder drained.
    msg.delete();
    for (int i = 0; i < 252; i++) msg.push_back(8'(i + 1));
    exp_bytes(MAX_BYTES);
    exp_res.push_back('{1'b1, 32'd1});
    send_msg(1'b0);
    wait_done("overflow");
    chk("err_code held after overflow", 128'(bus_if.err_code), 128'd1);

    msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    exp_bytes(9);
    exp_tail(1, 1'b0, 32'hE3069283);
    send_msg(1'b0);
    wait_done("after overflow");

    // STATUS 0, 0, then ERROR.
    stat_mode = 1;
    msg = '{8'h31};
    exp_bytes(1);
    exp_tail(3, 1'b1, 32'd2);
    send_msg(1'b0);
    wait_done("status error");

    // STATUS never ready: poll timeout.
    stat_mode = 2;
    msg = '{8'h5A};
    exp_bytes(1);
    exp_tail(POLL_TIMEOUT, 1'b1, 32'd3);
    send_msg(1'b0);
    wait_done("poll timeout");
    chk("err_code held after timeout", 128'(bus_if.err_code), 128'd3);
    chk("idle after timeout", 128'(bus_if.in_ready), 128'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
